pwm_capture: RTL and testbench

//   Receive-side counterpart of the motor PWM generators. Measures an incoming
//   PWM waveform (motor feedback / loop-back of the left or right motor line).

---
 rtl/pwm_capture.sv | 236 +++++++++++++++++++++++
 tb/tb_pwm_capture.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//   Measures an incoming PWM waveform (motor feedback or loop-back of a motor
//   line). Reports the period and the high time in clk cycles, plus a 10-bit
//   duty on the same 0..1023 scale the PWM generators accept. Declares loss of
//   signal when no rising edge arrives for TIMEOUT cycles.
//
// Parameters
//   CNT_W    width of the period/high-time counters and outputs
//   TIMEOUT  clk cycles without a rising edge before pwm_lost is declared
//
// Ports
//   clk         system clock
//   rst_n       asynchronous reset, active low. The upstream reset controller
//               releases it synchronously to clk.
//   pwm_in      asynchronous PWM input
//   duty        floor(high_time*1024/period), saturated at 1023
//   period      clk cycles between the last two rising edges
//   high_time   clk cycles pwm_in was high within that period
//   meas_valid  one-cycle pulse: duty/period/high_time updated
//   pwm_lost    level: no rising edge for TIMEOUT cycles
//   overrun     one-cycle pulse: a capture was dropped because the divider
//               was still busy
// -----------------------------------------------------------------------------
module pwm_capture #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [9:0]       duty,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             pwm_lost,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam int               DIV_ITER  = 11;
  localparam logic [3:0]       DIV_LAST  = 4'(DIV_ITER);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DIVIDE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Synchronizer / edge-history pipeline
  logic s1_p0, s2_p1, s3_p2;
  logic rise;

  // Free-running measurement counters
  logic [CNT_W-1:0] per_cnt, hi_cnt;
  logic [CNT_W-1:0] per_inc;

  // Control strobes from the FSM
  logic lost_hit, capture, div_run, div_done, ovr_d;

  // Divider datapath
  logic [CNT_W-1:0] div_den;   // captured period (divisor)
  logic [CNT_W-1:0] cap_hi;    // captured high time
  logic [CNT_W-1:0] div_rem;   // partial remainder, always < div_den
  logic [10:0]      div_num;   // numerator bits still to be shifted in
  logic [10:0]      div_quo;
  logic [3:0]       div_cnt;
  logic [CNT_W:0]   step_res;  // {quotient bit, next remainder}

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // The quotient can only reach 1024 when high_time == period; clamp it onto
  // the 10-bit generator scale.
  function automatic logic [9:0] sat_duty(input logic [10:0] q);
    return q[10] ? 10'd1023 : q[9:0];
  endfunction

  // One restoring-division step. The remainder stays below the divisor, so
  // the shifted value fits in CNT_W+1 bits and the difference in CNT_W bits.
  function automatic logic [CNT_W:0] div_step(input logic [CNT_W-1:0] rem,
                                              input logic [CNT_W-1:0] den,
                                              input logic             nbit);
    logic [CNT_W:0] sh;
    sh = {rem, nbit};
    if (sh >= {1'b0, den}) begin
      return {1'b1, sh[CNT_W-1:0] - den};
    end
    return {1'b0, sh[CNT_W-1:0]};
  endfunction

  // ---- stage p0..p2: input synchronizer and one cycle of edge history ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_p0 <= 1'b0;
      s2_p1 <= 1'b0;
      s3_p2 <= 1'b0;
    end else begin
      s1_p0 <= pwm_in;
      s2_p1 <= s1_p0;
      s3_p2 <= s2_p1;
    end
  end

  assign rise    = s2_p1 & ~s3_p2;
  assign per_inc = sat_inc(per_cnt);

  // A rise on the same cycle as the timeout wins, and a lost line is only
  // declared once until a rise re-arms it.
  assign lost_hit = ~rise & ~pwm_lost & (per_inc == TIMEOUT_C);

  assign div_run  = (state_q == DIVIDE) && (div_cnt != DIV_LAST);
  assign step_res = div_step(div_rem, div_den, div_num[10]);

  // ---- measurement counters ----
  // The rise cycle itself belongs to the new period and is a high cycle,
  // hence the restart at 1 for both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      per_cnt <= CNT_W'(1);
      hi_cnt  <= CNT_W'(1);
    end else begin
      per_cnt <= per_inc;
      if (s2_p1) begin
        hi_cnt <= sat_inc(hi_cnt);
      end
    end
  end

  // ---- FSM next state and strobes ----
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    div_done = 1'b0;
    ovr_d    = 1'b0;
    if (lost_hit) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            capture = 1'b1;
            state_d = DIVIDE;
          end
        end
        DIVIDE: begin
          if (rise) begin
            ovr_d = 1'b1;
          end
          if (div_cnt == DIV_LAST) begin
            div_done = 1'b1;
            state_d  = MEASURE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        div_cnt <= '0;
      end else if (div_run) begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // ---- divider datapath ----
  // Numerator is {hi, 10'b0}. Since hi <= period, the quotient fits in 11
  // bits, so the bits above numerator bit 10 (hi >> 1) preload the remainder
  // and only bit 10 (hi[0]) followed by ten zeros is shifted in.
  always_ff @(posedge clk) begin
    if (capture) begin
      div_den <= per_cnt;
      cap_hi  <= hi_cnt;
      div_rem <= hi_cnt >> 1;
      div_num <= {hi_cnt[0], 10'b0};
      div_quo <= '0;
    end else if (div_run) begin
      div_rem <= step_res[CNT_W-1:0];
      div_num <= {div_num[9:0], 1'b0};
      div_quo <= {div_quo[9:0], step_res[CNT_W]};
    end
  end

  // ---- registered outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty       <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      pwm_lost   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      overrun    <= ovr_d;
      if (rise) begin
        pwm_lost <= 1'b0;
      end
      if (lost_hit) begin
        // A stuck line reports full or zero duty depending on its level.
        pwm_lost   <= 1'b1;
        period     <= '0;
        high_time  <= '0;
        duty       <= s2_p1 ? 10'd1023 : 10'd0;
        meas_valid <= 1'b1;
      end else if (div_done) begin
        period     <= div_den;
        high_time  <= cap_hi;
        duty       <= sat_duty(div_quo);
        meas_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture
//   Drives pwm_capture with directed and random PWM waveforms and compares its
//   outputs every cycle against an event-level model: a rising edge reaches
//   the measurement logic two samples after pwm_in is first seen high, a
//   result appears 12 cycles after the rise that captures it, rises during
//   that window are dropped, and TIMEOUT cycles without a rise mean loss.
// -----------------------------------------------------------------------------
module tb_pwm_capture;

  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 4500;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pwm_in;
  logic [9:0]       duty;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             pwm_lost;
  logic             overrun;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int ovr_cnt = 0;

  // Input and reset values as seen by each active clock edge
  logic pwm_at_edge;
  logic rst_at_edge;

  // Model state
  bit     d1, d2, d3;            // pwm samples from 1, 2 and 3 edges ago
  longint n_edge = 0;
  longint m_elapsed, m_high;     // cycles since last rise, high cycles in it
  bit     m_armed, m_lost, m_pend;
  longint m_due, m_res_per, m_res_hi;
  longint e_duty, e_per, e_hi;
  bit     e_valid, e_lost, e_ovr;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .duty       (duty),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .pwm_lost   (pwm_lost),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pwm_at_edge <= pwm_in;
    rst_at_edge <= rst_n;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model + per-cycle compare ----------------
  initial begin : compare
    bit lvl, rise;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1 || rst_at_edge !== 1'b1) begin
        d1 = 0; d2 = 0; d3 = 0;
        m_elapsed = 0; m_high = 0;
        m_armed = 0; m_lost = 0; m_pend = 0;
        m_due = 0; m_res_per = 0; m_res_hi = 0;
        e_duty = 0; e_per = 0; e_hi = 0;
        e_valid = 0; e_lost = 0; e_ovr = 0;
      end else begin
        n_edge++;
        lvl  = d2;
        rise = d2 && !d3;
        e_valid = 0;
        e_ovr   = 0;
        if (rise) begin
          m_lost = 0;
          if (!m_armed) begin
            m_armed = 1;
          end else if (m_pend) begin
            e_ovr = 1;
          end else begin
            m_pend    = 1;
            m_due     = n_edge + 12;
            m_res_per = m_elapsed;
            m_res_hi  = m_high;
          end
          m_elapsed = 1;
          m_high    = 1;
        end else begin
          m_elapsed++;
          if (lvl) m_high++;
          if (m_elapsed == TIMEOUT && !m_lost) begin
            m_lost  = 1;
            e_per   = 0;
            e_hi    = 0;
            e_duty  = lvl ? 1023 : 0;
            e_valid = 1;
            m_pend  = 0;
            m_armed = 0;
          end
        end
        if (m_pend && n_edge == m_due) begin
          m_pend  = 0;
          e_per   = m_res_per;
          e_hi    = m_res_hi;
          e_duty  = (m_res_hi * 1024) / m_res_per;
          if (e_duty > 1023) e_duty = 1023;
          e_valid = 1;
        end
        e_lost = m_lost;
        d3 = d2; d2 = d1; d1 = pwm_at_edge;
      end
      chk("duty", longint'(duty), e_duty);
      chk("period", longint'(period), e_per);
      chk("high_time", longint'(high_time), e_hi);
      chk("meas_valid", longint'(meas_valid), longint'(e_valid));
      chk("pwm_lost", longint'(pwm_lost), longint'(e_lost));
      chk("overrun", longint'(overrun), longint'(e_ovr));
      if (meas_valid) valid_cnt++;
      if (overrun) ovr_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic v);
    pwm_in = v;
    @(posedge clk);
    #2;
  endtask

  task automatic wave(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < p; j++) cyc(j < h);
    end
  endtask

  // One PWM period whose first high sample is edge k; meas_valid must appear
  // exactly at edge k+14 and last a single cycle.
  task automatic latency_period(input int p, input int h);
    int lat;
    int used;
    pwm_in = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!meas_valid && lat < 40);
    chk("latency_edges", lat, 14);
    @(posedge clk);
    #1;
    chk("valid_width", longint'(meas_valid), 0);
    used = lat + 2;
    for (int j = used; j < p; j++) cyc(j < h);
  endtask

  initial begin : stim
    int v0, o0;
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_duty", longint'(duty), 0);
    chk("rst_period", longint'(period), 0);
    chk("rst_high", longint'(high_time), 0);
    chk("rst_valid", longint'(meas_valid), 0);
    chk("rst_lost", longint'(pwm_lost), 0);
    #1 rst_n = 1'b1;

    // 4000/1000 square wave, three periods; the third measures latency
    v0 = valid_cnt;
    wave(4000, 1000, 2);
    latency_period(4000, 1000);
    chk("t1_valids", valid_cnt - v0, 2);
    chk("t1_period", longint'(period), 4000);
    chk("t1_high", longint'(high_time), 1000);
    chk("t1_duty", longint'(duty), 256);
    chk("t1_model_duty", e_duty, 256);

    // generator duty 700 at period 4001
    wave(4001, 2734, 3);
    chk("t2_period", longint'(period), 4001);
    chk("t2_high", longint'(high_time), 2734);
    chk("t2_duty", longint'(duty), 699);
    chk("t2_model_duty", e_duty, 699);

    // loss while held low, then while held high, then recovery
    v0 = valid_cnt;
    repeat (TIMEOUT) cyc(1'b0);
    chk("t4_lost_low", longint'(pwm_lost), 1);
    chk("t4_duty_low", longint'(duty), 0);
    chk("t4_period_low", longint'(period), 0);
    chk("t4_high_low", longint'(high_time), 0);
    chk("t4_valids_low", valid_cnt - v0, 1);
    v0 = valid_cnt;
    repeat (TIMEOUT + 20) cyc(1'b1);
    chk("t4_lost_high", longint'(pwm_lost), 1);
    chk("t4_duty_high", longint'(duty), 1023);
    chk("t4_period_high", longint'(period), 0);
    chk("t4_valids_high", valid_cnt - v0, 1);
    repeat (100) cyc(1'b0);
    v0 = valid_cnt;
    for (int j = 0; j < 10; j++) cyc(1'b1);
    chk("t4_lost_clear", longint'(pwm_lost), 0);
    for (int j = 10; j < 4000; j++) cyc(j < 1000);
    chk("t4_no_valid_first", valid_cnt - v0, 0);
    wave(4000, 1000, 1);
    chk("t4_valids_rec", valid_cnt - v0, 1);
    chk("t4_duty_rec", longint'(duty), 256);
    chk("t4_period_rec", longint'(period), 4000);

    // short period: every other rise lands in DIVIDE
    o0 = ovr_cnt;
    wave(8, 4, 12);
    repeat (20) cyc(1'b0);
    chk("t5_overruns", ovr_cnt - o0, 6);
    chk("t5_period", longint'(period), 8);
    chk("t5_high", longint'(high_time), 4);
    chk("t5_duty", longint'(duty), 512);

    // reset in the middle of a divide
    for (int j = 0; j < 5; j++) cyc(1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_duty", longint'(duty), 0);
    chk("t6_period", longint'(period), 0);
    chk("t6_high", longint'(high_time), 0);
    chk("t6_valid", longint'(meas_valid), 0);
    chk("t6_overrun", longint'(overrun), 0);
    v0 = valid_cnt;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    repeat (200) cyc(1'b0);
    wave(4000, 1000, 1);
    chk("t6_no_valid", valid_cnt - v0, 0);
    wave(4000, 1000, 1);
    chk("t6_valid_after", valid_cnt - v0, 1);
    chk("t6_duty_after", longint'(duty), 256);

    // random waveforms, some short enough to provoke overruns
    for (int b = 0; b < 40; b++) begin
      int p, h, n;
      p = $urandom_range(((b % 3) == 0) ? 12 : 300, 2);
      h = $urandom_range(p - 1, 1);
      n = $urandom_range(4, 1);
      wave(p, h, n);
    end
    repeat (20) cyc(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
